// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef logic [1:0] byte_idx_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_t;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write bus of the loader.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              byte_valid;
  logic [BYTE_W-1:0] byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_byte_packer.sv
// MSB-first byte packer; with IMEM_LOADER_CHECKSUM_EN it also keeps a running
// XOR of every byte shifted in since the last restart.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             restart,
  input  logic                             clear,
  input  logic                             shift_en,
  input  logic [BYTE_W-1:0]                byte_in,
  output logic [BYTES_PER_WORD*BYTE_W-1:0] word_next,
  output logic                             word_full
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [BYTE_W-1:0]                csum
`endif
);
  localparam int WORD_W = BYTES_PER_WORD * BYTE_W;
  localparam byte_idx_t LAST_IDX = byte_idx_t'(BYTES_PER_WORD - 1);

  logic [WORD_W-1:0] word;
  byte_idx_t         idx;

  assign word_next = {word[WORD_W-BYTE_W-1:0], byte_in};
  // High while three bytes are held: the next shift completes the word.
  assign word_full = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      word <= '0;
      idx  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum <= '0;
`endif
    end else if (clear) begin
      idx <= '0;
    end else if (shift_en) begin
      word <= word_next;
      idx  <= idx + byte_idx_t'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum <= csum ^ byte_in;
`endif
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Loads a byte-streamed program into instruction memory and holds the core
// until complete. Optional trailing checksum byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              abort,
  imem_loader_if.master     bus,
  output logic              core_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_written
);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t                            state;
  logic [ADDR_W:0]                   len_q;
  logic [ADDR_W:0]                   ww_inc;
  logic                              transfer;
  logic                              len_ok;
  logic                              restart;
  logic [BYTES_PER_WORD*BYTE_W-1:0]  word_next;
  logic                              word_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]                 csum;
`endif

  assign transfer = bus.byte_valid && bus.byte_ready;
  assign len_ok   = (load_len != '0) && (load_len <= MAX_LEN);
  assign restart  = start && ((state == S_IDLE) || (state == S_DONE));
  assign ww_inc   = words_written + {{ADDR_W{1'b0}}, 1'b1};

  imem_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .clear     (state == S_WRITE),
    .shift_en  (transfer && (state == S_RECV)),
    .byte_in   (bus.byte_data),
    .word_next (word_next),
    .word_full (word_full)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .csum      (csum)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      len_q          <= '0;
      bus.byte_ready <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      core_hold      <= 1'b1;
      done           <= 1'b0;
      err            <= 1'b0;
      words_written  <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            words_written <= '0;
            len_q         <= load_len;
            if (len_ok) begin
              state          <= S_RECV;
              bus.byte_ready <= 1'b1;
              done           <= 1'b0;
              err            <= 1'b0;
              core_hold      <= 1'b1;
            end else begin
              state     <= S_DONE;
              done      <= 1'b1;
              err       <= 1'b1;
              core_hold <= 1'b0;
            end
          end
        end
        S_RECV: begin
          if (abort) begin
            state          <= S_IDLE;
            bus.byte_ready <= 1'b0;
          end else if (transfer && word_full) begin
            // Strobe is registered here so it lands in the WRITE cycle.
            state          <= S_WRITE;
            bus.byte_ready <= 1'b0;
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= words_written[ADDR_W-1:0];
            bus.imem_wdata <= word_next;
          end
        end
        S_WRITE: begin
          words_written <= ww_inc;
          if (abort) begin
            state <= S_IDLE;
          end else if (ww_inc == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state          <= S_CHECK;
            bus.byte_ready <= 1'b1;
`else
            state     <= S_DONE;
            done      <= 1'b1;
            core_hold <= 1'b0;
`endif
          end else begin
            state          <= S_RECV;
            bus.byte_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (abort) begin
            state          <= S_IDLE;
            bus.byte_ready <= 1'b0;
          end else if (transfer) begin
            state          <= S_DONE;
            bus.byte_ready <= 1'b0;
            done           <= 1'b1;
            core_hold      <= 1'b0;
            err            <= (bus.byte_data != csum);
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a stream-level model predicts every write
// strobe and committed-word count; literal checks pin the model.
module tb_imem_loader;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [ADDR_W:0] load_len;
  logic            abort;
  logic            core_hold;
  logic            done;
  logic            err;
  logic [ADDR_W:0] words_written;

  imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .load_len      (load_len),
    .abort         (abort),
    .bus           (bus.master),
    .core_hold     (core_hold),
    .done          (done),
    .err           (err),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Stream model: bytes accepted while a legal load is active form words
  // MSB-first; a completed word must be strobed on the following cycle and
  // counted as committed one cycle later.
  bit          m_active = 0;
  int          m_len = 0, m_words = 0, m_cnt = 0, m_ww = 0;
  logic [31:0] m_word = '0;
  bit          exp_we = 0;
  int          exp_addr = 0;
  logic [31:0] exp_data = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_cnt = 0; m_words = 0; m_ww = 0; exp_we = 0;
    end else begin
      if (exp_we) m_ww++;
      exp_we = 0;
      if (m_active && abort) begin
        m_active = 0;
        m_cnt    = 0;
      end else if (!m_active && start) begin
        m_len    = int'(load_len);
        m_words  = 0;
        m_ww     = 0;
        m_cnt    = 0;
        m_active = (m_len >= 1) && (m_len <= (1 << ADDR_W));
      end else if (m_active && bus.byte_valid && bus.byte_ready) begin
        m_word = {m_word[23:0], bus.byte_data};
        m_cnt++;
        if (m_cnt == 4) begin
          exp_we   = 1;
          exp_addr = m_words;
          exp_data = m_word;
          m_words++;
          m_cnt = 0;
          if (m_words == m_len) m_active = 0;
        end
      end
    end
  end

  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];

  always @(negedge clk) begin
    if (!rst) begin
      check("imem_we", bus.imem_we, exp_we);
      if (exp_we && bus.imem_we) begin
        check("imem_addr", bus.imem_addr, exp_addr);
        check("imem_wdata", bus.imem_wdata, exp_data);
      end
      check("words_written", words_written, m_ww);
      if (bus.imem_we) begin
        wr_addr.push_back(bus.imem_addr);
        wr_data.push_back(bus.imem_wdata);
      end
    end
  end

  logic [7:0] csum_acc;

  task automatic do_start(input int len);
    start    = 1'b1;
    load_len = (ADDR_W+1)'(len);
    csum_acc = '0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("byte_ready_wait", bus.byte_ready, 1'b1);
    csum_acc = csum_acc ^ b;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic finish_load(input logic [7:0] csum_byte);
    int n = 0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(csum_byte, 0);
`else
    if (csum_byte == 8'h00) n = 0;
`endif
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("done_wait", done, 1'b1);
  endtask

  logic [7:0] prog [8];
  int base;

  initial begin
    prog = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h22, 8'h00, 8'h04};
    rst = 1'b1; start = 1'b0; abort = 1'b0; load_len = '0;
    bus.byte_valid = 1'b0; bus.byte_data = '0; csum_acc = '0;

    repeat (2) @(negedge clk);
    check("rst_core_hold", core_hold, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_imem_we", bus.imem_we, 1'b0);
    check("rst_byte_ready", bus.byte_ready, 1'b0);
    check("rst_words_written", words_written, 0);
    check("rst_imem_addr", bus.imem_addr, 0);
    check("rst_imem_wdata", bus.imem_wdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back load of two words.
    base = wr_addr.size();
    do_start(2);
    check("start_core_hold", core_hold, 1'b1);
    foreach (prog[i]) send_byte(prog[i], 0);
    finish_load(csum_acc);
    check("norm_writes", wr_addr.size() - base, 2);
    check("norm_addr0", wr_addr[base], 0);
    check("norm_data0", wr_data[base], 32'h20010005);
    check("norm_addr1", wr_addr[base+1], 1);
    check("norm_data1", wr_data[base+1], 32'h8C220004);
    check("norm_done", done, 1'b1);
    check("norm_core_hold", core_hold, 1'b0);
    check("norm_ww", words_written, 2);
    check("norm_err", err, 1'b0);
    check("done_addr_hold", bus.imem_addr, 1);
    check("done_wdata_hold", bus.imem_wdata, 32'h8C220004);

    // Same load with three idle cycles between bytes.
    base = wr_addr.size();
    do_start(2);
    foreach (prog[i]) send_byte(prog[i], 3);
    finish_load(csum_acc);
    check("stall_writes", wr_addr.size() - base, 2);
    check("stall_data0", wr_data[base], 32'h20010005);
    check("stall_data1", wr_data[base+1], 32'h8C220004);
    check("stall_ww", words_written, 2);

    // Illegal lengths.
    base = wr_addr.size();
    do_start(0);
    repeat (3) @(negedge clk);
    check("len0_done", done, 1'b1);
    check("len0_err", err, 1'b1);
    check("len0_core_hold", core_hold, 1'b0);
    check("len0_byte_ready", bus.byte_ready, 1'b0);
    do_start(33);
    repeat (3) @(negedge clk);
    check("len33_done", done, 1'b1);
    check("len33_err", err, 1'b1);
    check("len33_core_hold", core_hold, 1'b0);
    check("bad_len_writes", wr_addr.size() - base, 0);

    // Abort mid-word, then reload a single word.
    base = wr_addr.size();
    do_start(2);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_byte_ready", bus.byte_ready, 1'b0);
    check("abort_core_hold", core_hold, 1'b1);
    check("abort_done", done, 1'b0);
    repeat (2) @(negedge clk);
    check("abort_writes", wr_addr.size() - base, 0);
    do_start(1);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
    finish_load(csum_acc);
    check("reload_writes", wr_addr.size() - base, 1);
    check("reload_addr", wr_addr[base], 0);
    check("reload_data", wr_data[base], 32'hAABBCCDD);
    check("reload_done", done, 1'b1);

    // Largest legal load ends at the top address.
    base = wr_addr.size();
    do_start(32);
    for (int k = 0; k < 128; k++) send_byte(8'(k), 0);
    finish_load(csum_acc);
    check("full_writes", wr_addr.size() - base, 32);
    check("full_last_addr", wr_addr[base+31], 31);
    check("full_last_data", wr_data[base+31], 32'h7C7D7E7F);
    check("full_ww", words_written, 32);
    check("full_done", done, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_start(1);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    finish_load(8'h44);
    check("csum_ok_err", err, 1'b0);
    check("csum_ok_done", done, 1'b1);
    do_start(1);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    finish_load(8'h45);
    check("csum_bad_err", err, 1'b1);
    check("csum_bad_done", done, 1'b1);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1);
  end
endmodule
